// File: rtl/layer_weight_bank.sv
// Layer/row-addressed weight and bias store fed by the upload sequencer.
// Tracks upload completion and serves rows through a one-cycle registered read port.
module layer_weight_bank #(
  parameter int layers                = 2,
  parameter int datawidth             = 11,
  parameter int rows [0:layers-1]     = '{30, 10},
  parameter int max_rows              = 30,
  parameter int max_cols              = 64,
  localparam int LW = (layers > 1) ? $clog2(layers) : 1,
  localparam int RW = (max_rows > 1) ? $clog2(max_rows) : 1
) (
  input  logic                            clk,
  input  logic                            rst_overall,
  input  logic                            train,
  input  logic [LW-1:0]                   layer_select,
  input  logic [RW-1:0]                   row_select,
  input  logic [max_cols*datawidth-1:0]   weight_update,
  input  logic [max_rows*2*datawidth-1:0] bias_updates,
  input  logic                            upload_done,
  input  logic                            rd_req,
  input  logic [LW-1:0]                   rd_layer,
  input  logic [RW-1:0]                   rd_row,
  output logic                            rd_valid,
  output logic [max_cols*datawidth-1:0]   rd_weights,
  output logic [2*datawidth-1:0]          rd_bias,
  output logic                            rd_err,
  output logic                            wr_err,
  output logic [layers-1:0]               layer_loaded,
  output logic                            bank_ready
);

  localparam int RCW = RW + 1;
  localparam int WW  = max_cols * datawidth;
  localparam int BW  = 2 * datawidth;
  localparam int BVW = max_rows * BW;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    READY   = 2'd2
  } state_t;

  state_t state;

  logic [WW-1:0]  weight_mem [layers][max_rows];
  logic [BVW-1:0] bias_mem   [layers];

  // Valid row count of a layer; zero for a layer index outside the bank,
  // so a single "row < count" test also rejects bad layer addresses.
  function automatic logic [RCW-1:0] row_count(input logic [LW-1:0] l);
    logic [RCW-1:0] n;
    n = '0;
    for (int i = 0; i < layers; i++)
      if (int'(l) == i) n = RCW'(rows[i]);
    return n;
  endfunction

  logic [RCW-1:0]   wr_rows;
  logic             wr_hit;
  logic             wr_last;
  logic [layers-1:0] wr_onehot;
  logic [layers-1:0] loaded_nxt;

  logic [RCW-1:0]   rd_rows;
  logic             rd_ok;
  logic [RW-1:0]    bias_idx;
  logic [BVW-1:0]   bias_row;
  logic [BW-1:0]    bias_word;

  always_comb begin
    wr_rows = row_count(layer_select);
    wr_hit  = train && ({1'b0, row_select} < wr_rows);
    wr_last = wr_hit && ({1'b0, row_select} == (wr_rows - RCW'(1)));
    for (int i = 0; i < layers; i++)
      wr_onehot[i] = (int'(layer_select) == i);
  end

  // A reload beat in READY keeps only the bit of the layer being rewritten.
  always_comb begin
    loaded_nxt = layer_loaded;
    if (wr_hit) begin
      if (state == READY) loaded_nxt = layer_loaded & wr_onehot;
      if (wr_last)        loaded_nxt = loaded_nxt | wr_onehot;
    end
  end

  always_comb begin
    rd_rows  = row_count(rd_layer);
    rd_ok    = rd_req && (state == READY) && !wr_hit && ({1'b0, rd_row} < rd_rows);
    bias_idx = RW'(rd_rows - RCW'(1) - {1'b0, rd_row});
    bias_row = bias_mem[rd_layer];
    bias_word = '0;
    for (int i = 0; i < max_rows; i++)
      if (int'(bias_idx) == i) bias_word = bias_row[i*BW +: BW];
  end

  // Storage arrays carry no reset; contents survive reset but are gated by state.
  always_ff @(posedge clk) begin
    if (wr_hit) begin
      weight_mem[layer_select][row_select] <= weight_update;
      bias_mem[layer_select]               <= bias_updates;
    end
  end

  always_ff @(posedge clk or posedge rst_overall) begin
    if (rst_overall) begin
      state        <= EMPTY;
      layer_loaded <= '0;
      bank_ready   <= 1'b0;
      wr_err       <= 1'b0;
      rd_err       <= 1'b0;
      rd_valid     <= 1'b0;
      rd_weights   <= '0;
      rd_bias      <= '0;
    end else begin
      rd_valid     <= rd_ok;
      rd_err       <= rd_req && !rd_ok;
      wr_err       <= train && !wr_hit;
      layer_loaded <= loaded_nxt;
      if (rd_ok) begin
        rd_weights <= weight_mem[rd_layer][rd_row];
        rd_bias    <= bias_word;
      end
      case (state)
        EMPTY: begin
          if (wr_hit) state <= LOADING;
        end
        LOADING: begin
          if (upload_done) begin
            if (&loaded_nxt) begin
              state      <= READY;
              bank_ready <= 1'b1;
            end else begin
              wr_err <= 1'b1;
            end
          end
        end
        READY: begin
          if (wr_hit) begin
            state      <= LOADING;
            bank_ready <= 1'b0;
          end
        end
        default: begin
          state      <= EMPTY;
          bank_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layer_weight_bank.sv
// Directed bench for layer_weight_bank: upload, readiness, bias mapping, errors, reload, reset.
module tb_layer_weight_bank;

  localparam int DW = 11;
  localparam int MC = 64;
  localparam int MR = 30;
  localparam int BW = 22;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_overall;
  logic              train;
  logic [0:0]        layer_select;
  logic [4:0]        row_select;
  logic [MC*DW-1:0]  weight_update;
  logic [MR*BW-1:0]  bias_updates;
  logic              upload_done;
  logic              rd_req;
  logic [0:0]        rd_layer;
  logic [4:0]        rd_row;
  logic              rd_valid;
  logic [MC*DW-1:0]  rd_weights;
  logic [BW-1:0]     rd_bias;
  logic              rd_err;
  logic              wr_err;
  logic [1:0]        layer_loaded;
  logic              bank_ready;

  int checks = 0;
  int errors = 0;

  layer_weight_bank dut (
    .clk(clk), .rst_overall(rst_overall), .train(train),
    .layer_select(layer_select), .row_select(row_select),
    .weight_update(weight_update), .bias_updates(bias_updates),
    .upload_done(upload_done), .rd_req(rd_req), .rd_layer(rd_layer),
    .rd_row(rd_row), .rd_valid(rd_valid), .rd_weights(rd_weights),
    .rd_bias(rd_bias), .rd_err(rd_err), .wr_err(wr_err),
    .layer_loaded(layer_loaded), .bank_ready(bank_ready)
  );

  // Layer 0 words are offset by 500 so the two layers never alias.
  function automatic logic [MC*DW-1:0] mk_row(input int l, input int r);
    logic [MC*DW-1:0] v;
    v = '0;
    for (int c = 0; c < MC; c++) v[c*DW +: DW] = DW'((l == 0 ? 500 : 0) + r + c);
    return v;
  endfunction

  // Bias for row i sits in chunk (rows-1-i); layer 0 row i = 100+i, layer 1 row i = 300+i.
  function automatic logic [MR*BW-1:0] mk_bias(input int l);
    logic [MR*BW-1:0] v;
    int n;
    int base;
    n    = (l == 0) ? 30 : 10;
    base = (l == 0) ? 100 : 300;
    v    = '0;
    for (int i = 0; i < n; i++) v[(n-1-i)*BW +: BW] = BW'(base + i);
    return v;
  endfunction

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic beat(input int l, input int r, input logic done);
    train = 1'b1; layer_select = 1'(l); row_select = 5'(r);
    weight_update = mk_row(l, r); bias_updates = mk_bias(l); upload_done = done;
    @(posedge clk); #1;
    train = 1'b0; upload_done = 1'b0;
  endtask

  task automatic load_layer(input int l, input int n);
    for (int r = 0; r < n; r++) beat(l, r, 1'b0);
    beat(l, n - 1, 1'b0);
  endtask

  task automatic pulse_done();
    upload_done = 1'b1;
    @(posedge clk); #1;
    upload_done = 1'b0;
  endtask

  task automatic read(input int l, input int r);
    rd_req = 1'b1; rd_layer = 1'(l); rd_row = 5'(r);
    @(posedge clk); #1;
    rd_req = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
    checks++; if (rd_err !== 1'b0) begin errors++; $display("FAIL reset_rd_err got %b exp 0", rd_err); end
    checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL reset_wr_err got %b exp 0", wr_err); end
    checks++; if (bank_ready !== 1'b0) begin errors++; $display("FAIL reset_bank_ready got %b exp 0", bank_ready); end
    checks++; if (layer_loaded !== 2'b00) begin errors++; $display("FAIL reset_layer_loaded got %b exp 00", layer_loaded); end
    checks++; if (rd_weights !== '0) begin errors++; $display("FAIL reset_rd_weights got %h exp 0", rd_weights); end
    checks++; if (rd_bias !== '0) begin errors++; $display("FAIL reset_rd_bias got %h exp 0", rd_bias); end
  endtask

  task automatic test_full_upload();
    load_layer(0, 30);
    load_layer(1, 10);
    checks++; if (layer_loaded !== 2'b11) begin errors++; $display("FAIL full_loaded got %b exp 11", layer_loaded); end
    checks++; if (bank_ready !== 1'b0) begin errors++; $display("FAIL full_ready_early got %b exp 0", bank_ready); end
    pulse_done();
    checks++; if (bank_ready !== 1'b1) begin errors++; $display("FAIL full_ready got %b exp 1", bank_ready); end
    checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL full_wr_err got %b exp 0", wr_err); end
    read(1, 3);
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL full_rd_valid got %b exp 1", rd_valid); end
    checks++; if (rd_weights[DW-1:0] !== 11'd3) begin errors++; $display("FAIL full_word0 got %0d exp 3", rd_weights[DW-1:0]); end
    checks++; if (rd_weights !== mk_row(1, 3)) begin errors++; $display("FAIL full_row got %h exp %h", rd_weights, mk_row(1, 3)); end
    checks++; if (rd_bias !== 22'd303) begin errors++; $display("FAIL full_bias got %0d exp 303", rd_bias); end
    idle();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL full_valid_pulse got %b exp 0", rd_valid); end
    checks++; if (rd_weights !== mk_row(1, 3)) begin errors++; $display("FAIL full_hold got %h exp %h", rd_weights, mk_row(1, 3)); end
  endtask

  task automatic test_back_to_back_bias();
    rd_req = 1'b1; rd_layer = 1'b0; rd_row = 5'd0;
    @(posedge clk); #1;
    checks++; if (rd_bias !== 22'd100) begin errors++; $display("FAIL bias_row0 got %0d exp 100", rd_bias); end
    checks++; if (rd_weights !== mk_row(0, 0)) begin errors++; $display("FAIL b2b_row0 got %h exp %h", rd_weights, mk_row(0, 0)); end
    rd_row = 5'd29;
    @(posedge clk); #1;
    rd_req = 1'b0;
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b exp 1", rd_valid); end
    checks++; if (rd_bias !== 22'd129) begin errors++; $display("FAIL bias_row29 got %0d exp 129", rd_bias); end
    checks++; if (rd_weights !== mk_row(0, 29)) begin errors++; $display("FAIL b2b_row29 got %h exp %h", rd_weights, mk_row(0, 29)); end
  endtask

  task automatic test_range_errors();
    beat(1, 12, 1'b0);
    checks++; if (wr_err !== 1'b1) begin errors++; $display("FAIL range_wr_err got %b exp 1", wr_err); end
    checks++; if (bank_ready !== 1'b1) begin errors++; $display("FAIL range_ready got %b exp 1", bank_ready); end
    checks++; if (layer_loaded !== 2'b11) begin errors++; $display("FAIL range_loaded got %b exp 11", layer_loaded); end
    idle();
    checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL range_wr_err_pulse got %b exp 0", wr_err); end
    read(1, 10);
    checks++; if (rd_err !== 1'b1) begin errors++; $display("FAIL range_rd_err got %b exp 1", rd_err); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL range_rd_valid got %b exp 0", rd_valid); end
    read(1, 9);
    checks++; if (rd_err !== 1'b0) begin errors++; $display("FAIL range_last_rd_err got %b exp 0", rd_err); end
    checks++; if (rd_weights !== mk_row(1, 9)) begin errors++; $display("FAIL range_last_row got %h exp %h", rd_weights, mk_row(1, 9)); end
  endtask

  task automatic test_conflict_reload();
    train = 1'b1; layer_select = 1'b0; row_select = 5'd5;
    weight_update = mk_row(0, 5); bias_updates = mk_bias(0);
    rd_req = 1'b1; rd_layer = 1'b0; rd_row = 5'd5;
    @(posedge clk); #1;
    train = 1'b0; rd_req = 1'b0;
    checks++; if (rd_err !== 1'b1) begin errors++; $display("FAIL conflict_rd_err got %b exp 1", rd_err); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL conflict_rd_valid got %b exp 0", rd_valid); end
    checks++; if (bank_ready !== 1'b0) begin errors++; $display("FAIL conflict_ready got %b exp 0", bank_ready); end
    checks++; if (layer_loaded !== 2'b01) begin errors++; $display("FAIL conflict_loaded got %b exp 01", layer_loaded); end
    read(0, 5);
    checks++; if (rd_err !== 1'b1) begin errors++; $display("FAIL loading_rd_err got %b exp 1", rd_err); end
  endtask

  task automatic test_incomplete();
    for (int r = 0; r < 9; r++) beat(1, r, 1'b0);
    checks++; if (layer_loaded !== 2'b01) begin errors++; $display("FAIL incomplete_loaded got %b exp 01", layer_loaded); end
    pulse_done();
    checks++; if (wr_err !== 1'b1) begin errors++; $display("FAIL incomplete_wr_err got %b exp 1", wr_err); end
    checks++; if (bank_ready !== 1'b0) begin errors++; $display("FAIL incomplete_ready got %b exp 0", bank_ready); end
    read(1, 0);
    checks++; if (rd_err !== 1'b1) begin errors++; $display("FAIL incomplete_rd_err got %b exp 1", rd_err); end
    checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL incomplete_wr_pulse got %b exp 0", wr_err); end
  endtask

  task automatic test_write_with_done();
    beat(1, 9, 1'b1);
    checks++; if (bank_ready !== 1'b1) begin errors++; $display("FAIL wdone_ready got %b exp 1", bank_ready); end
    checks++; if (layer_loaded !== 2'b11) begin errors++; $display("FAIL wdone_loaded got %b exp 11", layer_loaded); end
    checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL wdone_wr_err got %b exp 0", wr_err); end
    read(0, 5);
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL wdone_rd_valid got %b exp 1", rd_valid); end
    checks++; if (rd_weights !== mk_row(0, 5)) begin errors++; $display("FAIL wdone_row got %h exp %h", rd_weights, mk_row(0, 5)); end
    checks++; if (rd_bias !== 22'd105) begin errors++; $display("FAIL wdone_bias got %0d exp 105", rd_bias); end
  endtask

  task automatic test_async_reset();
    read(1, 9);
    checks++; if (rd_weights !== mk_row(1, 9)) begin errors++; $display("FAIL prerst_row got %h exp %h", rd_weights, mk_row(1, 9)); end
    for (int r = 0; r < 15; r++) beat(0, r, 1'b0);
    checks++; if (layer_loaded !== 2'b01) begin errors++; $display("FAIL prerst_loaded got %b exp 01", layer_loaded); end
    train = 1'b1; layer_select = 1'b0; row_select = 5'd15;
    weight_update = mk_row(0, 15); bias_updates = mk_bias(0);
    #2 rst_overall = 1'b1;
    #1;
    checks++; if (layer_loaded !== 2'b00) begin errors++; $display("FAIL arst_loaded got %b exp 00", layer_loaded); end
    checks++; if (bank_ready !== 1'b0) begin errors++; $display("FAIL arst_ready got %b exp 0", bank_ready); end
    checks++; if (rd_weights !== '0) begin errors++; $display("FAIL arst_rd_weights got %h exp 0", rd_weights); end
    checks++; if (rd_bias !== '0) begin errors++; $display("FAIL arst_rd_bias got %h exp 0", rd_bias); end
    checks++; if ({rd_valid, rd_err, wr_err} !== 3'b000) begin errors++; $display("FAIL arst_pulses got %b exp 000", {rd_valid, rd_err, wr_err}); end
    @(posedge clk); #1;
    train = 1'b0;
    rst_overall = 1'b0;
    pulse_done();
    checks++; if (bank_ready !== 1'b0) begin errors++; $display("FAIL empty_done_ready got %b exp 0", bank_ready); end
    checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL empty_done_wr_err got %b exp 0", wr_err); end
    read(0, 0);
    checks++; if (rd_err !== 1'b1) begin errors++; $display("FAIL empty_rd_err got %b exp 1", rd_err); end
    load_layer(0, 30);
    load_layer(1, 10);
    pulse_done();
    checks++; if (bank_ready !== 1'b1) begin errors++; $display("FAIL reupload_ready got %b exp 1", bank_ready); end
    read(0, 29);
    checks++; if (rd_weights !== mk_row(0, 29)) begin errors++; $display("FAIL reupload_row got %h exp %h", rd_weights, mk_row(0, 29)); end
    checks++; if (rd_bias !== 22'd129) begin errors++; $display("FAIL reupload_bias got %0d exp 129", rd_bias); end
  endtask

  initial begin
    rst_overall = 1'b1; train = 1'b0; upload_done = 1'b0; rd_req = 1'b0;
    layer_select = '0; row_select = '0; rd_layer = '0; rd_row = '0;
    weight_update = '0; bias_updates = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_overall = 1'b0;
    idle();
    test_full_upload();
    test_back_to_back_bias();
    test_range_errors();
    test_conflict_reload();
    test_incomplete();
    test_write_with_done();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
